ps2_rx_fifo: RTL
================

# ps2_rx_fifo

PS/2 keyboard receiver with a scan-code FIFO, sitting upstream of the game and firmware logic that consumes key presses. Deserializes 11-bit PS/2 frames from the keyboard pins, checks start, parity and stop bits, and buffers good bytes. A polled register pair lets the picorv32 address decoder (or the game logic) pop scan codes and read error status without losing keystrokes during long firmware loops.

## Interface
- FIFO_DEPTH, 8: scan-code entries; power of two, 2..16.
- TIMEOUT_CYCLES, 20000: clk cycles without a PS/2 falling edge before a partial frame is aborted (200 µs at 100 MHz).

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- clk_ps2  in  1  raw PS/2 clock pin, asynchronous.
- data  in  1  raw PS/2 data pin, asynchronous.
- rd_strb  in  1  one-cycle read request from the bus decoder.
- rd_addr  in  1  0 = DATA register, 1 = STATUS register.
- rdata  out  32  registered read data.
- rd_ack  out  1  one-cycle acknowledge for rd_strb.
- irq  out  1  level: FIFO non-empty.

## Operation
- Input conditioning: clk_ps2 and data each pass through a 2-flop synchronizer. A third clk_ps2 flop gives edge detection. fall = prev 1, current 0. All sampling uses synchronized data on fall.
- Receive FSM states:
  - IDLE: on fall with data=0 go to DATA, bitcnt=0. On fall with data=1 stay (glitch/false start, no error).
  - DATA: shift data into shreg LSB first. After 8th bit go to PARITY.
  - PARITY: latch parity bit, go to STOP.
  - STOP: on fall, good frame = (data==1) and (^shreg ^ parity == 1) (odd parity). Good frame → push request. Otherwise set frame_err. Go to IDLE in all cases.
- Timeout: 15-bit-or-wider counter cleared on every fall and while in IDLE. Outside IDLE, counter reaching TIMEOUT_CYCLES → IDLE, frame_err set, partial byte discarded.
- FIFO: circular buffer, wr/rd pointers of log2(FIFO_DEPTH) bits wrap modulo depth. count is log2(FIFO_DEPTH)+1 bits.
  - Push with FIFO full and no same-cycle pop: byte dropped, overflow set.
  - Push and pop in the same cycle: both happen, count unchanged. This also applies when full, so no overflow.
- DATA read (rd_addr=0):
  - Non-empty: rdata = {23'b0, 1'b1, head}, and the entry is popped.
  - Empty: rdata = 0, no pop, no error.
- STATUS read (rd_addr=1):
  - rdata[0] = non-empty, [1] = full, [2] = overflow, [3] = frame_err, [8:4] = count (zero-extended), rest 0.
  - overflow and frame_err are clear-on-read. An error event in the same cycle as the status read wins: flag stays 1 after the read, and the read value shows the pre-event state.
- irq = (count != 0), registered from count.

## Timing
- Reset values: rdata=0, rd_ack=0, irq=0, FSM=IDLE, pointers/count=0, overflow=0, frame_err=0, shreg=0.
- Reset asserted mid-frame: partial frame discarded. After release, the FSM waits in IDLE for a new start bit. Any trailing bits of the interrupted frame are treated as start/glitch per IDLE rules.
- Pin-to-fall detect latency: 3 clk.
- Push: count/irq update 1 clk after the fall that samples the stop bit. Byte is readable on the next rd_strb.
- rd_strb at cycle N → rd_ack=1 and rdata valid at N+1. rdata holds until the next read. rd_ack is high only at N+1.
- Pop and flag clear take effect at N+1. rd_strb on consecutive cycles is legal: each is an independent read.
- PS/2 bit period (60–100 µs) far exceeds internal latency. No backpressure toward the keyboard; clk_ps2 is never driven.

## Test plan
- Good frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1), then DATA read → irq rises 1 clk after stop fall; rdata=0x0000011C, rd_ack pulse; irq falls; second DATA read → rdata=0.
- Frame with parity flipped to 1, then STATUS read → FIFO empty, rdata[3]=1. Second STATUS read → rdata=0.
- Stop bit 0 on a valid 0xF0 frame → no push, frame_err=1. Following good 0x29 frame → pushed normally.
- TIMEOUT_CYCLES=50, start bit plus 3 data bits then clk_ps2 idle high for 60 clk → FSM back to IDLE, frame_err=1. Next full 0x5A frame → received correctly.
- FIFO_DEPTH=4, 5 good frames 0x01..0x05 → STATUS = full, count=4, overflow=1. DATA reads return 0x01..0x04 in order, then 0.
- FIFO full and DATA read in the same cycle as a push of 0x66 → no overflow, count stays 4, 0x66 is the last entry read. Also assert reset mid-frame → all outputs 0 and next frame received intact.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo_if
// Polled register bus between the bus decoder (master) and the PS/2
// receiver (slave).
//   rd_strb : one-cycle read request from the decoder
//   rd_addr : 0 = DATA register, 1 = STATUS register
//   rdata   : registered read data returned by the receiver
//   rd_ack  : one-cycle acknowledge, the cycle after rd_strb
//   irq     : level interrupt, high while the scan-code FIFO holds data
// ---------------------------------------------------------------------------
interface ps2_rx_fifo_if;
  logic        rd_strb;
  logic        rd_addr;
  logic [31:0] rdata;
  logic        rd_ack;
  logic        irq;

  // Bus decoder side
  modport master (
    output rd_strb,
    output rd_addr,
    input  rdata,
    input  rd_ack,
    input  irq
  );

  // PS/2 receiver side
  modport slave (
    input  rd_strb,
    input  rd_addr,
    output rdata,
    output rd_ack,
    output irq
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 keyboard receiver with a scan-code FIFO. Deserializes 11-bit frames
// (start, 8 data LSB first, odd parity, stop) from the raw keyboard pins,
// buffers good bytes and exposes a polled DATA/STATUS register pair.
//   clk     : system clock
//   reset   : asynchronous, active-high, clears all state
//   clk_ps2 : raw PS/2 clock pin (asynchronous)
//   data    : raw PS/2 data pin (asynchronous)
//   bus     : register read port (rd_strb, rd_addr, rdata, rd_ack, irq)
// Parameters:
//   FIFO_DEPTH     : scan-code entries, power of two, 2..16
//   TIMEOUT_CYCLES : clk cycles without a PS/2 falling edge before a partial
//                    frame is abandoned
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clk_ps2,
  input  logic           data,
  ps2_rx_fifo_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 15) ? $clog2(TIMEOUT_CYCLES + 1) : 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rxState_e;

  // -------------------------------------------------------------------------
  // Pin conditioning. Both pins get a 2-flop synchronizer; a third flop on
  // the clock pin remembers the previous level so a falling edge can be seen.
  // Idle PS/2 lines are high, so the flops reset high to avoid a phantom
  // edge right after reset.
  // -------------------------------------------------------------------------
  logic [1:0] clkSync_q;
  logic       clkPrev_q;
  logic [1:0] dataSync_q;
  logic       ps2Fall;
  logic       ps2Bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkSync_q  <= 2'b11;
      clkPrev_q  <= 1'b1;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[0], clk_ps2};
      clkPrev_q  <= clkSync_q[1];
      dataSync_q <= {dataSync_q[0], data};
    end
  end

  assign ps2Fall = clkPrev_q & ~clkSync_q[1];
  assign ps2Bit  = dataSync_q[1];

  // -------------------------------------------------------------------------
  // Receive FSM state register, together with the shift register, bit
  // counter, latched parity bit and the inactivity timer it owns.
  // -------------------------------------------------------------------------
  rxState_e         state_q, state_d;
  logic [7:0]       shiftReg_q, shiftReg_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic             parity_q, parity_d;
  logic [TMO_W-1:0] timeoutCnt_q, timeoutCnt_d;
  logic             pushReq;
  logic             frameErrEv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shiftReg_q   <= '0;
      bitCnt_q     <= '0;
      parity_q     <= 1'b0;
      timeoutCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      shiftReg_q   <= shiftReg_d;
      bitCnt_q     <= bitCnt_d;
      parity_q     <= parity_d;
      timeoutCnt_q <= timeoutCnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Receive FSM next state. Every bit is taken on a synchronized falling
  // edge. A high bit seen while idle is a glitch, not an error. At the stop
  // bit the frame is good only with stop=1 and odd parity over data+parity.
  // The timer runs only mid-frame; if it expires the partial byte is dropped
  // and a frame error is flagged.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shiftReg_d   = shiftReg_q;
    bitCnt_d     = bitCnt_q;
    parity_d     = parity_q;
    timeoutCnt_d = timeoutCnt_q + TMO_W'(1);
    pushReq      = 1'b0;
    frameErrEv   = 1'b0;

    if (state_q == ST_IDLE || ps2Fall) begin
      timeoutCnt_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ps2Fall && !ps2Bit) begin
          state_d  = ST_DATA;
          bitCnt_d = '0;
        end
      end
      ST_DATA: begin
        if (ps2Fall) begin
          shiftReg_d = {ps2Bit, shiftReg_q[7:1]};
          bitCnt_d   = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (ps2Fall) begin
          parity_d = ps2Bit;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (ps2Fall) begin
          if (ps2Bit && ((^shiftReg_q) ^ parity_q)) begin
            pushReq = 1'b1;
          end else begin
            frameErrEv = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_q != ST_IDLE && !ps2Fall && timeoutCnt_q == TMO_W'(TIMEOUT_CYCLES)) begin
      state_d      = ST_IDLE;
      shiftReg_d   = '0;
      timeoutCnt_d = '0;
      frameErrEv   = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO control. A DATA read pops only when there is something to pop.
  // A push into a full FIFO still lands if a pop happens in the same cycle,
  // because the slot being freed is exactly the one the write pointer hits.
  // -------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             isEmpty, isFull;
  logic             dataRead, statusRead;
  logic             pop, push, overflowEv;

  assign isEmpty    = (count_q == '0);
  assign isFull     = (count_q == CNT_W'(FIFO_DEPTH));
  assign dataRead   = bus.rd_strb & ~bus.rd_addr;
  assign statusRead = bus.rd_strb & bus.rd_addr;
  assign pop        = dataRead & ~isEmpty;
  assign push       = pushReq & (~isFull | pop);
  assign overflowEv = pushReq & isFull & ~pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at the depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr_q] <= shiftReg_q;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags, cleared by a STATUS read. A new event in the same
  // cycle as the read wins so no error is ever silently lost.
  // -------------------------------------------------------------------------
  logic overflow_q;
  logic frameErr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      if (overflowEv) begin
        overflow_q <= 1'b1;
      end else if (statusRead) begin
        overflow_q <= 1'b0;
      end
      if (frameErrEv) begin
        frameErr_q <= 1'b1;
      end else if (statusRead) begin
        frameErr_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read port. Read data is captured from the pre-edge state so a STATUS
  // read reports flags as they were before any same-cycle event. rdata holds
  // its value between reads. irq follows the next occupancy so it moves in
  // the same cycle as the count.
  // -------------------------------------------------------------------------
  logic [31:0] statusWord;
  logic [31:0] dataWord;
  logic [31:0] rdata_q;
  logic        rdAck_q;
  logic        irq_q;

  assign statusWord = {23'b0, 5'(count_q), frameErr_q, overflow_q, isFull, ~isEmpty};
  assign dataWord   = isEmpty ? 32'b0 : {23'b0, 1'b1, mem[rdPtr_q]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      rdAck_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      rdAck_q <= bus.rd_strb;
      if (bus.rd_strb) begin
        rdata_q <= bus.rd_addr ? statusWord : dataWord;
      end
      irq_q <= (count_d != '0);
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rd_ack = rdAck_q;
  assign bus.irq    = irq_q;

endmodule
